// File: rtl/dffram_pkg.sv
// Shared types and defaults for the dual-port DFF RAM macro.
package dffram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int BYTE_W = 8;

    localparam int DEF_WSIZE      = 4;
    localparam int DEF_A_WIDTH    = 8;
    localparam bit DEF_REG_OUT    = 1'b0;
    localparam bit DEF_INIT_CLEAR = 1'b1;

endpackage

// File: rtl/dffram_1r1w_if.sv
// Port bundle for dffram_1r1w: one write port, one read port, clear request and busy flag.
interface dffram_1r1w_if
    import dffram_pkg::*;
#(
    parameter int WSIZE   = DEF_WSIZE,
    parameter int A_WIDTH = DEF_A_WIDTH
);
    localparam int DW = BYTE_W * WSIZE;

    logic               EN0;
    logic [WSIZE-1:0]   WE0;
    logic [A_WIDTH-1:0] A0;
    logic [DW-1:0]      Di0;
    logic               EN1;
    logic [A_WIDTH-1:0] A1;
    logic [DW-1:0]      Do1;
    logic               CLR;
    logic               BUSY;

    modport master (
        output EN0, WE0, A0, Di0, EN1, A1, CLR,
        input  Do1, BUSY
    );

    modport slave (
        input  EN0, WE0, A0, Di0, EN1, A1, CLR,
        output Do1, BUSY
    );

endinterface

// File: rtl/dffram_clear_seq.sv
// Clear sequencer: walks every address once writing zeros, either after reset
// release or on a CLR request, and flags busy while doing so.
module dffram_clear_seq
    import dffram_pkg::*;
#(
    parameter int A_WIDTH    = DEF_A_WIDTH,
    parameter bit INIT_CLEAR = DEF_INIT_CLEAR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_req,
    output logic               busy,
    output logic [A_WIDTH-1:0] clr_addr,
    output logic               clr_we
);

    localparam state_e RESET_STATE = INIT_CLEAR ? CLEAR : IDLE;

    state_e             state_q, state_d;
    logic [A_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A CLR seen while already clearing is ignored; the sequence never restarts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == '1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + A_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/dffram_1r1w.sv
// Parametrised 1-write/1-read DFF RAM with byte-lane writes, write-first
// forwarding, optional output register and a hardware clear sequencer.
module dffram_1r1w
    import dffram_pkg::*;
#(
    parameter int WSIZE      = DEF_WSIZE,
    parameter int A_WIDTH    = DEF_A_WIDTH,
    parameter bit REG_OUT    = DEF_REG_OUT,
    parameter bit INIT_CLEAR = DEF_INIT_CLEAR
) (
    input  logic          CLK,
    input  logic          RST_N,
    dffram_1r1w_if.slave  bus
);

    localparam int DW        = BYTE_W * WSIZE;
    localparam int NUM_WORDS = 2 ** A_WIDTH;

    logic [DW-1:0]      mem [NUM_WORDS];

    logic               busy;
    logic               clr_we;
    logic [A_WIDTH-1:0] clr_addr;

    logic [WSIZE-1:0]   wr_lane;
    logic [A_WIDTH-1:0] wr_addr;
    logic [DW-1:0]      wr_data;
    logic               fwd_hit;
    logic [DW-1:0]      rd_d, rd_q;

    dffram_clear_seq #(
        .A_WIDTH    (A_WIDTH),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_clear_seq (
        .clk      (CLK),
        .rst_n    (RST_N),
        .clr_req  (bus.CLR),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    // The clear sequencer owns the write port while busy; user writes are dropped.
    always_comb begin
        wr_lane = '0;
        wr_addr = bus.A0;
        wr_data = bus.Di0;
        if (busy) begin
            wr_lane = {WSIZE{clr_we}};
            wr_addr = clr_addr;
            wr_data = '0;
        end else if (bus.EN0) begin
            wr_lane = bus.WE0;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < WSIZE; i++) begin
            if (wr_lane[i]) begin
                mem[wr_addr][BYTE_W*i +: BYTE_W] <= wr_data[BYTE_W*i +: BYTE_W];
            end
        end
    end

    // Write-first: a same-address write in this cycle supplies its enabled lanes.
    always_comb begin
        rd_d    = '0;
        fwd_hit = bus.EN0 && (bus.A0 == bus.A1);
        if (!busy && bus.EN1) begin
            for (int i = 0; i < WSIZE; i++) begin
                if (fwd_hit && bus.WE0[i]) begin
                    rd_d[BYTE_W*i +: BYTE_W] = bus.Di0[BYTE_W*i +: BYTE_W];
                end else begin
                    rd_d[BYTE_W*i +: BYTE_W] = mem[bus.A1][BYTE_W*i +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    generate
        if (REG_OUT) begin : g_out_reg
            logic [DW-1:0] out_q;
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    out_q <= '0;
                end else begin
                    out_q <= rd_q;
                end
            end
            assign bus.Do1 = out_q;
        end else begin : g_no_out_reg
            assign bus.Do1 = rd_q;
        end
    endgenerate

    assign bus.BUSY = busy;

endmodule

// File: tb/tb_dffram_1r1w.sv
// Scoreboard bench for dffram_1r1w: one instance without and one with the output
// register, driven by identical directed vectors.
module tb_dffram_1r1w;

    localparam int WSIZE   = 4;
    localparam int A_WIDTH = 4;
    localparam int NWORDS  = 2 ** A_WIDTH;

    typedef struct {
        int          due;
        bit          is_busy;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic CLK;
    logic RST_N;
    int   cyc;
    int   checks;
    int   failures;

    exp_t q0[$];
    exp_t q1[$];

    dffram_1r1w_if #(.WSIZE(WSIZE), .A_WIDTH(A_WIDTH)) bus0 ();
    dffram_1r1w_if #(.WSIZE(WSIZE), .A_WIDTH(A_WIDTH)) bus1 ();

    assign bus1.EN0 = bus0.EN0;
    assign bus1.WE0 = bus0.WE0;
    assign bus1.A0  = bus0.A0;
    assign bus1.Di0 = bus0.Di0;
    assign bus1.EN1 = bus0.EN1;
    assign bus1.A1  = bus0.A1;
    assign bus1.CLR = bus0.CLR;

    dffram_1r1w #(
        .WSIZE(WSIZE), .A_WIDTH(A_WIDTH), .REG_OUT(1'b0), .INIT_CLEAR(1'b1)
    ) dut0 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus0.slave)
    );

    dffram_1r1w #(
        .WSIZE(WSIZE), .A_WIDTH(A_WIDTH), .REG_OUT(1'b1), .INIT_CLEAR(1'b1)
    ) dut1 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus1.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d actual=0x%08h expected=0x%08h", name, cyc, act, exp);
        end
    endtask

    // Monitor: each falling edge, retire every expectation that falls due now.
    always @(negedge CLK) begin
        for (int i = q0.size() - 1; i >= 0; i--) begin
            if (q0[i].due <= cyc) begin
                if (q0[i].due < cyc)
                    checkOutput({q0[i].name, "_missed0"}, 32'hFFFF_FFFF, 32'h0);
                else if (q0[i].is_busy)
                    checkOutput({q0[i].name, "_busy0"}, {31'd0, bus0.BUSY}, q0[i].exp);
                else
                    checkOutput({q0[i].name, "_do0"}, bus0.Do1, q0[i].exp);
                q0.delete(i);
            end
        end
        for (int i = q1.size() - 1; i >= 0; i--) begin
            if (q1[i].due <= cyc) begin
                if (q1[i].due < cyc)
                    checkOutput({q1[i].name, "_missed1"}, 32'hFFFF_FFFF, 32'h0);
                else if (q1[i].is_busy)
                    checkOutput({q1[i].name, "_busy1"}, {31'd0, bus1.BUSY}, q1[i].exp);
                else
                    checkOutput({q1[i].name, "_do1"}, bus1.Do1, q1[i].exp);
                q1.delete(i);
            end
        end
    end

    task automatic expData(input string name, input logic [31:0] exp);
        q0.push_back('{cyc + 1, 1'b0, exp, name});
        q1.push_back('{cyc + 2, 1'b0, exp, name});
    endtask

    task automatic expNow(input string name, input logic [31:0] exp);
        q0.push_back('{cyc, 1'b0, exp, name});
        q1.push_back('{cyc, 1'b0, exp, name});
    endtask

    task automatic expBusy(input string name, input int due, input bit exp);
        q0.push_back('{due, 1'b1, {31'd0, exp}, name});
        q1.push_back('{due, 1'b1, {31'd0, exp}, name});
    endtask

    task automatic applyStimulus(
        input logic        en0,
        input logic [3:0]  we0,
        input logic [3:0]  a0,
        input logic [31:0] di0,
        input logic        en1,
        input logic [3:0]  a1,
        input logic        clr
    );
        bus0.EN0 = en0;
        bus0.WE0 = we0;
        bus0.A0  = a0;
        bus0.Di0 = di0;
        bus0.EN1 = en1;
        bus0.A1  = a1;
        bus0.CLR = clr;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle;
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        int r;
        int c;
        int d;
        checks   = 0;
        failures = 0;
        RST_N    = 1'b0;
        idle();
        tick();
        tick();

        expBusy("reset", cyc, 1'b1);
        expNow("reset", 32'h0);
        tick();

        // Initial clear after reset release; a write mid-clear must be dropped.
        RST_N = 1'b1;
        r = cyc;
        for (int k = 0; k <= NWORDS; k++) expBusy("init_clear", r + k, k < NWORDS);
        for (int k = 0; k < NWORDS; k++) begin
            applyStimulus(k == 10, 4'hF, 4'd3, 32'h1234_5678, 1'b1, 4'(k), 1'b0);
            expData("busy_read", 32'h0);
            tick();
        end
        for (int a = 0; a < NWORDS; a++) begin
            applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a), 1'b0);
            expData("cleared_read", 32'h0);
            tick();
        end

        applyStimulus(1'b1, 4'hF, 4'd5, 32'hDEAD_BEEF, 1'b0, 4'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'b0100, 4'd5, 32'h00AA_0000, 1'b0, 4'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b0);
        expData("byte_lane", 32'hDEAA_BEEF);
        tick();
        applyStimulus(1'b1, 4'hF, 4'd7, 32'h1122_3344, 1'b0, 4'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'b0011, 4'd7, 32'hAABB_CCDD, 1'b1, 4'd7, 1'b0);
        expData("forward", 32'h1122_CCDD);
        tick();
        applyStimulus(1'b1, 4'hF, 4'd8, 32'h0102_0304, 1'b1, 4'd5, 1'b0);
        expData("no_fwd_other_addr", 32'hDEAA_BEEF);
        tick();
        applyStimulus(1'b1, 4'h0, 4'd2, 32'hFFFF_FFFF, 1'b1, 4'd7, 1'b0);
        expData("after_forward", 32'h1122_CCDD);
        tick();
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd8, 1'b0);
        expData("read8", 32'h0102_0304);
        tick();
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd5, 1'b0);
        expData("en1_low", 32'h0);
        tick();
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2, 1'b0);
        expData("we0_zero", 32'h0);
        tick();

        // CLR with a read in the same cycle; a second CLR mid-clear must not extend it.
        c = cyc;
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b1);
        expData("clr_cycle_read", 32'hDEAA_BEEF);
        for (int k = 0; k <= NWORDS + 1; k++)
            expBusy("clr_busy", c + k, (k >= 1) && (k <= NWORDS));
        tick();
        for (int k = 0; k < NWORDS; k++) begin
            applyStimulus(k == 12, 4'hF, 4'd5, 32'hFFFF_FFFF, 1'b1, 4'd8, k == 4);
            expData("clr_busy_read", 32'h0);
            tick();
        end
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b0);
        expData("after_clr5", 32'h0);
        tick();
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd7, 1'b0);
        expData("after_clr7", 32'h0);
        tick();
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd8, 1'b0);
        expData("after_clr8", 32'h0);
        tick();

        // Reset while the sequencer is at address 9; clear restarts from 0 in full.
        d = cyc;
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1);
        tick();
        idle();
        repeat (9) tick();
        RST_N = 1'b0;
        expBusy("rst_mid_clear", cyc, 1'b1);
        tick();
        RST_N = 1'b1;
        r = cyc;
        for (int k = 0; k <= NWORDS; k++) expBusy("restart_clear", r + k, k < NWORDS);
        repeat (NWORDS) tick();
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd0, 1'b0);
        expData("restart_read0", 32'h0);
        tick();
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd15, 1'b0);
        expData("restart_read15", 32'h0);
        tick();
        idle();

        for (int w = 0; w < 8 && (q0.size() != 0 || q1.size() != 0); w++) tick();
        @(negedge CLK);
        #1;
        foreach (q0[i]) begin
            failures++;
            $display("[TB] FAIL %s_timeout0 due=%0d actual=unchecked expected=0x%08h", q0[i].name, q0[i].due, q0[i].exp);
        end
        foreach (q1[i]) begin
            failures++;
            $display("[TB] FAIL %s_timeout1 due=%0d actual=unchecked expected=0x%08h", q1[i].name, q1[i].due, q1[i].exp);
        end
        if (d < 0) $display("[TB] unexpected cycle value");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dffram_1r1w.md
# dffram_1r1w

Parametrised successor to the fixed 256x32 single-port DFFRAM. Provides one write port and one independent read port sharing a clock, byte-lane write enables of configurable count, an optional output register, same-cycle read/write forwarding and a hardware clear sequencer that zeroes the array after reset or on request. It sits beside CPU/peripheral blocks as a small scratchpad or register-file macro.

## Interface
- WSIZE, 4: bytes per word; data width DW = 8*WSIZE.
- A_WIDTH, 8: address width; NUM_WORDS = 2**A_WIDTH.
- REG_OUT, 0: 1 adds an output pipeline register (read latency 2).
- INIT_CLEAR, 1: 1 starts a clear sequence on reset release.

- CLK  in  1  single clock, all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- EN0  in  1  write port enable.
- WE0  in  WSIZE  byte-lane write enables; lane i covers Di0[8i+7:8i].
- A0  in  A_WIDTH  write address.
- Di0  in  DW  write data.
- EN1  in  1  read port enable.
- A1  in  A_WIDTH  read address.
- Do1  out  DW  read data.
- CLR  in  1  single-cycle request to zero the whole array.
- BUSY  out  1  clear sequence in progress; port accesses ignored.

## Operation
- States: IDLE, CLEAR. Reset enters CLEAR if INIT_CLEAR=1, else IDLE; clear counter resets to 0.
- CLEAR: writes all-zero word to address cnt each cycle, cnt increments; after writing NUM_WORDS-1 go IDLE, cnt returns to 0.
- IDLE: CLR=1 enters CLEAR (cnt=0). CLR during CLEAR ignored (no restart).
- BUSY = (state==CLEAR), registered.
- Write (IDLE, EN0=1): each lane with WE0[i]=1 updates that byte of RAM[A0]; other lanes unchanged. EN0=0 or WE0=0: no write.
- Read (IDLE, EN1=1): read stage captures RAM[A1]. EN1=0: read stage captures 0 (matches predecessor behaviour).
- Forwarding: EN0=1, EN1=1, A0==A1 in same cycle: Do1 returns new bytes for enabled lanes, old bytes for others (write-first).
- During BUSY: EN0 writes dropped; reads return 0 regardless of EN1.
- Array storage flops are not reset; contents defined only after a completed clear or writes.

## Timing
- Reset: Do1=0, output register=0, BUSY=INIT_CLEAR, state per above.
- Read latency: 1 cycle (REG_OUT=0), 2 cycles (REG_OUT=1); fully pipelined, one read per cycle.
- Write visible to a read issued the next cycle (and same cycle via forwarding).
- Clear duration: exactly NUM_WORDS cycles with BUSY=1; BUSY falls on the edge after the last zero write; port access in that first BUSY=0 cycle is accepted.
- CLR sampled in IDLE takes effect next edge: BUSY=1 the following cycle; a port access in the CLR cycle itself is still performed.
- RST_N asserted mid-clear: state/counter reset immediately; with INIT_CLEAR=1 clear restarts from address 0 on release; with 0, array left partially cleared.
- Counter width A_WIDTH; terminal compare on all-ones, no wrap beyond NUM_WORDS-1.

## Structure
- Package dffram_pkg: state enum (IDLE, CLEAR), byte width constant 8, default parameter values.
- Sub-module dffram_clear_seq: FSM plus address counter, outputs BUSY, clear address, clear write strobe; top muxes it onto the write port.
- Top holds array, lane-write logic, forwarding compare, read and optional output register.

## Test plan
- Reset release, INIT_CLEAR=1, A_WIDTH=4 -> BUSY high exactly 16 cycles; then reads of addresses 0..15 return 0.
- Write 0xDEADBEEF to A0=5, WE0=4'hF; next cycle WE0=4'b0100 Di0=0x00AA0000 -> read A1=5 returns 0xDEAABEEF.
- Same-cycle EN0/EN1 A0=A1=7, old 0x11223344, Di0=0xAABBCCDD, WE0=4'b0011 -> Do1=0x1122CCDD (1 cycle, REG_OUT=0; 2 cycles, REG_OUT=1).
- EN1=0 after valid read -> Do1=0 next cycle; writes during BUSY dropped (location reads 0 after clear).
- CLR pulse in IDLE with stored data -> BUSY next cycle for NUM_WORDS cycles; CLR pulse mid-clear does not extend it.
- RST_N low at clear address 9 -> BUSY reasserts, clear restarts at 0, full NUM_WORDS cycles after release.
